led_mode_mux: RTL and testbench

//  Output stage downstream of the LED mode drivers (mode1..modeN). Selects one

---
 rtl/led_pkg.sv | 16 +
 rtl/led_pwm_gate.sv | 27 ++
 rtl/led_mode_mux.sv | 125 ++++++++++++
 tb/tb_led_mode_mux.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED output stage.
// Mode index type and crossfade FSM states.
package led_pkg;

  localparam int LED_W_DEF     = 8;
  localparam int NUM_MODES_DEF = 4;
  localparam int MODE_W_DEF    = $clog2(NUM_MODES_DEF);

  typedef logic [MODE_W_DEF-1:0] mode_idx_t;

  typedef enum logic {
    IDLE,
    FADE
  } led_state_e;

endpackage

// File: rtl/led_pwm_gate.sv
// Free-running PWM counter with level compare.
// o_on is high for i_level of every PERIOD clocks.
module led_pwm_gate #(
  parameter int PERIOD = 16,
  parameter int W      = $clog2(PERIOD) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_level,
  output logic         o_on
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == W'(PERIOD - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_on = (r_cnt < i_level);

endmodule

// File: rtl/led_mode_mux.sv
// LED output stage: mode select, old->new crossfade on mode change,
// and global brightness gating into a registered LED drive.
module led_mode_mux
  import led_pkg::*;
#(
  parameter int NUM_MODES   = NUM_MODES_DEF,
  parameter int LED_W       = LED_W_DEF,
  parameter int FADE_STEPS  = 16,
  parameter int STEP_CYCLES = 24000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_next,
  input  logic [NUM_MODES*LED_W-1:0]   mode_in,
  input  logic [3:0]                   bright,
  output logic [LED_W-1:0]             led_out,
  output logic [$clog2(NUM_MODES)-1:0] mode_cur,
  output logic                         busy
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int BW = $clog2(FADE_STEPS) + 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  led_state_e       r_state, w_state_nx;
  logic [MW-1:0]    r_mode, w_mode_nx;
  logic [MW-1:0]    r_old, w_old_nx;
  logic [BW-1:0]    r_lvl, w_lvl_nx;
  logic [SW-1:0]    r_step, w_step_nx;
  logic             r_pend, w_pend_nx;
  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_new, w_prev, w_pat;
  logic             w_blend_on, w_dim_on, w_gate, w_wrap;
  logic [MW-1:0]    w_mode_inc;

  led_pwm_gate #(
    .PERIOD (FADE_STEPS),
    .W      (BW)
  ) u_blend (
    .clk     (clk),
    .rst     (rst),
    .i_level (r_lvl),
    .o_on    (w_blend_on)
  );

  led_pwm_gate #(
    .PERIOD (16),
    .W      (4)
  ) u_dim (
    .clk     (clk),
    .rst     (rst),
    .i_level (bright),
    .o_on    (w_dim_on)
  );

  // old/new are indices, so live driver changes show through mid-fade
  assign w_new  = mode_in[int'(r_mode)*LED_W +: LED_W];
  assign w_prev = mode_in[int'(r_old)*LED_W +: LED_W];
  assign w_pat  = (r_state == FADE && !w_blend_on) ? w_prev : w_new;
  assign w_gate = (bright == 4'hF) | w_dim_on;

  assign w_wrap = (r_step == SW'(STEP_CYCLES - 1));
  assign w_mode_inc = (r_mode == MW'(NUM_MODES - 1)) ?
                      '0 : r_mode + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_old_nx   = r_old;
    w_lvl_nx   = r_lvl;
    w_step_nx  = r_step;
    w_pend_nx  = r_pend;
    unique case (r_state)
      IDLE: begin
        if (mode_next | r_pend) begin
          w_old_nx   = r_mode;
          w_mode_nx  = w_mode_inc;
          w_lvl_nx   = '0;
          w_step_nx  = '0;
          w_pend_nx  = 1'b0;
          w_state_nx = FADE;
        end
      end
      FADE: begin
        if (mode_next) w_pend_nx = 1'b1;
        if (w_wrap) begin
          w_step_nx = '0;
          if (r_lvl == BW'(FADE_STEPS - 1)) begin
            w_state_nx = IDLE;
          end else begin
            w_lvl_nx = r_lvl + 1'b1;
          end
        end else begin
          w_step_nx = r_step + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_old   <= '0;
      r_lvl   <= '0;
      r_step  <= '0;
      r_pend  <= 1'b0;
      r_led   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_old   <= w_old_nx;
      r_lvl   <= w_lvl_nx;
      r_step  <= w_step_nx;
      r_pend  <= w_pend_nx;
      r_led   <= w_pat & {LED_W{w_gate}};
    end
  end

  assign led_out  = r_led;
  assign mode_cur = r_mode;
  assign busy     = (r_state == FADE);

endmodule

// File: tb/tb_led_mode_mux.sv
// Scoreboard bench for led_mode_mux against a cycle-count reference model.
// Driver pushes expected outputs; monitor pops and compares each cycle.
module tb_led_mode_mux;

  localparam int NM = 4;
  localparam int LW = 8;
  localparam int FS = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_next = 1'b0;
  logic [31:0]   mode_in = '0;
  logic [3:0]    bright = '0;
  logic [LW-1:0] led_out;
  logic [1:0]    mode_cur;
  logic          busy;

  always #5 clk = ~clk;

  led_mode_mux #(
    .NUM_MODES   (NM),
    .LED_W       (LW),
    .FADE_STEPS  (FS),
    .STEP_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_next (mode_next),
    .mode_in   (mode_in),
    .bright    (bright),
    .led_out   (led_out),
    .mode_cur  (mode_cur),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] led;
    int         mode;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: elapsed fade cycles and cycles since reset
  int m_mode = 0;
  int m_old = 0;
  int m_t = 0;
  int m_k = 0;
  bit m_fading = 1'b0;
  bit m_pend = 1'b0;

  function automatic logic [7:0] pat(input logic [31:0] mi, input int idx);
    return mi[idx*8 +: 8];
  endfunction

  task automatic step(input bit r, input bit mn,
                      input logic [31:0] mi, input logic [3:0] br);
    exp_t e;
    logic [7:0] p;
    bit g;
    int lvl;
    @(negedge clk);
    rst = r;
    mode_next = mn;
    mode_in = mi;
    bright = br;
    if (r) begin
      m_mode = 0; m_old = 0; m_t = 0; m_k = 0;
      m_fading = 0; m_pend = 0;
      e.led = 8'h00; e.mode = 0; e.busy = 1'b0;
    end else begin
      g = (br == 4'hF) || ((m_k % 16) < int'(br));
      if (!m_fading) begin
        p = pat(mi, m_mode);
        if (mn || m_pend) begin
          m_old = m_mode;
          m_mode = (m_mode + 1) % NM;
          m_t = 0;
          m_pend = 0;
          m_fading = 1;
        end
      end else begin
        lvl = m_t / SC;
        p = ((m_k % FS) < lvl) ? pat(mi, m_mode) : pat(mi, m_old);
        if (mn) m_pend = 1;
        m_t++;
        if (m_t == FS * SC) m_fading = 0;
      end
      e.led = g ? p : 8'h00;
      e.mode = m_mode;
      e.busy = m_fading;
      m_k++;
    end
    q.push_back(e);
  endtask

  task automatic pulse_wait(input logic [31:0] mi, input logic [3:0] br,
                            input int n);
    step(1'b0, 1'b1, mi, br);
    repeat (n) step(1'b0, 1'b0, mi, br);
  endtask

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", n, $time, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("led_out", {24'h0, led_out}, {24'h0, e.led});
        chk("mode_cur", {30'h0, mode_cur}, e.mode[31:0]);
        chk("busy", {31'h0, busy}, {31'h0, e.busy});
      end
    end
  end

  initial begin
    logic [31:0] mi;
    logic [3:0]  br;
    bit r, mn;
    repeat (3) step(1'b1, 1'b1, $urandom, 4'hF);
    mi = 32'h0000_00FF;
    repeat (4) step(1'b0, 1'b0, mi, 4'hF);
    mi = 32'h0000_FF00;
    pulse_wait(mi, 4'hF, 20);
    mi = 32'hA55A_3CC3;
    pulse_wait(mi, 4'hF, 18);
    pulse_wait(mi, 4'hF, 18);
    step(1'b0, 1'b1, mi, 4'hF);
    repeat (2) step(1'b0, 1'b0, mi, 4'hF);
    repeat (3) begin
      step(1'b0, 1'b1, mi, 4'hF);
      repeat (2) step(1'b0, 1'b0, mi, 4'hF);
    end
    repeat (40) step(1'b0, 1'b0, mi, 4'hF);
    mi = 32'hFFFF_FFFF;
    repeat (20) step(1'b0, 1'b0, mi, 4'h0);
    repeat (32) step(1'b0, 1'b0, mi, 4'h4);
    mi = 32'h0F0F_F0F0;
    pulse_wait(mi, 4'hF, 6);
    repeat (2) step(1'b1, 1'b0, mi, 4'hF);
    repeat (6) step(1'b0, 1'b0, mi, 4'hF);
    br = 4'hF;
    repeat (3000) begin
      r  = ($urandom_range(0, 399) == 0);
      mn = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mi = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       br = 4'h0;
          1:       br = 4'hF;
          default: br = 4'($urandom);
        endcase
      end
      step(r, mn, mi, br);
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
